// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the two-digit scan driver.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_A,
        SHOW_U,
        BLANK_B,
        SHOW_T
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry 0 is the rightmost element.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

endpackage

// File: rtl/seg7_scan2_if.sv
// Digit inputs and display outputs of the scan driver.
// slave = the driver, master = whoever feeds digits and watches pins.
interface seg7_scan2_if;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic       blank_lz;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    modport master (
        output digit1, digit2, blank_lz,
        input  an, seg, dp, frame
    );

    modport slave (
        input  digit1, digit2, blank_lz,
        output an, seg, dp, frame
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 show a dash.
module bcd_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup for valid BCD, dash otherwise
    always_comb begin
        o_seg = SEG_DASH;
        unique case (i_bcd)
            4'd0: o_seg = SEG_TABLE[0];
            4'd1: o_seg = SEG_TABLE[1];
            4'd2: o_seg = SEG_TABLE[2];
            4'd3: o_seg = SEG_TABLE[3];
            4'd4: o_seg = SEG_TABLE[4];
            4'd5: o_seg = SEG_TABLE[5];
            4'd6: o_seg = SEG_TABLE[6];
            4'd7: o_seg = SEG_TABLE[7];
            4'd8: o_seg = SEG_TABLE[8];
            4'd9: o_seg = SEG_TABLE[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed common-anode display driver with
// blanking gaps and once-per-frame digit snapshot.
module seg7_scan2
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan2_if.slave  bus
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ?
                          REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] LD_SHOW  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LD_BLANK = CW'(BLANK_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_snap;
    logic [3:0]      r_d_u;
    logic [3:0]      r_d_t;
    logic [3:0]      w_bcd;
    logic [6:0]      w_dec;
    logic [1:0]      w_an;
    logic [6:0]      w_seg;
    logic [1:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_frame;

    assign w_snap = (r_state == BLANK_A) && (r_cnt == '0);

    // Next state: count down, advance and reload at zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 1'b1;
        if (r_cnt == '0) begin
            unique case (r_state)
                BLANK_A: begin
                    w_state_nxt = SHOW_U;
                    w_cnt_nxt   = LD_SHOW;
                end
                SHOW_U: begin
                    w_state_nxt = BLANK_B;
                    w_cnt_nxt   = LD_BLANK;
                end
                BLANK_B: begin
                    w_state_nxt = SHOW_T;
                    w_cnt_nxt   = LD_SHOW;
                end
                default: begin
                    w_state_nxt = BLANK_A;
                    w_cnt_nxt   = LD_BLANK;
                end
            endcase
        end
    end

    // State and timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK_A;
            r_cnt   <= LD_BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Digit snapshot on the last BLANK_A cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_u <= '0;
            r_d_t <= '0;
        end else if (w_snap) begin
            r_d_u <= bus.digit1;
            r_d_t <= bus.digit2;
        end
    end

    assign w_bcd = (r_state == SHOW_T) ? r_d_t : r_d_u;

    bcd_to_seg u_dec (
        .i_bcd (w_bcd),
        .o_seg (w_dec)
    );

    // Anode/segment selection, tens blanked on leading zero
    always_comb begin
        w_an  = 2'b11;
        w_seg = SEG_BLANK;
        unique case (r_state)
            SHOW_U: begin
                w_an  = 2'b10;
                w_seg = w_dec;
            end
            SHOW_T: begin
                if (!(bus.blank_lz && (r_d_t == 4'd0))) begin
                    w_an  = 2'b01;
                    w_seg = w_dec;
                end
            end
            default: begin
                w_an  = 2'b11;
                w_seg = SEG_BLANK;
            end
        endcase
    end

    // Registered outputs, dark in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an    <= 2'b11;
            r_seg   <= SEG_BLANK;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_frame <= w_snap;
        end
    end

    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
    assign bus.frame = r_frame;
    assign bus.dp    = 1'b1;

endmodule
